// File: rtl/sbox_array.sv
// Multi-lane AES S-box with an elastic pipeline of LAT stages (1 or 2).
// Per-beat selection between forward SubBytes and InvSubBytes.
module sbox_array #(
    parameter int LANES  = 4,
    parameter int LAT    = 2,
    parameter int INV_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_data,
    input  logic                 in_inv,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic                 out_inv
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int unsigned n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] y;
        y = gf_inv(x);
        return y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] s);
        return gf_inv(rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05);
    endfunction

    logic [8*LANES-1:0] lut;
    logic               mode;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [7:0] b;
        logic [7:0] fwd;
        assign b   = in_data[8*g +: 8];
        assign fwd = sbox_fwd(b);
        if (INV_EN != 0) begin : g_inv
            logic [7:0] inv;
            assign inv          = sbox_inv(b);
            assign lut[8*g +: 8] = in_inv ? inv : fwd;
        end else begin : g_fwd
            assign lut[8*g +: 8] = fwd;
        end
    end

    if (INV_EN != 0) begin : g_mode_inv
        assign mode = in_inv;
    end else begin : g_mode_fwd
        assign mode = 1'b0;
    end

    logic               s1_v;
    logic               s1_m;
    logic [8*LANES-1:0] s1_d;
    logic               s1_load;

    assign in_ready = s1_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
            s1_m <= 1'b0;
            s1_d <= '0;
        end else if (s1_load) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_d <= lut;
                s1_m <= mode;
            end
        end
    end

    if (LAT == 2) begin : g_two
        logic               s2_v;
        logic               s2_m;
        logic [8*LANES-1:0] s2_d;
        logic               s2_load;

        // Each stage loads when empty or when its occupant leaves this cycle.
        assign s2_load = ~s2_v | out_ready;
        assign s1_load = ~s1_v | s2_load;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_v <= 1'b0;
                s2_m <= 1'b0;
                s2_d <= '0;
            end else if (s2_load) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    s2_d <= s1_d;
                    s2_m <= s1_m;
                end
            end
        end

        assign out_valid = s2_v;
        assign out_data  = s2_d;
        assign out_inv   = s2_m;
    end else begin : g_one
        assign s1_load   = ~s1_v | out_ready;
        assign out_valid = s1_v;
        assign out_data  = s1_d;
        assign out_inv   = s1_m;
    end

endmodule

// File: tb/tb_sbox_array.sv
// Randomized and directed bench for sbox_array: four configurations checked
// against a table-driven reference model and an in-order scoreboard.
module tb_sbox_array;

    localparam logic [2047:0] SB = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    logic         clk;
    logic         rst_n;
    logic [3:0]   iv, ir, ov, ordy, oi;
    logic [127:0] din;
    logic         dinv;
    logic [31:0]  od0;
    logic [7:0]   od1;
    logic [127:0] od2;
    logic [7:0]   od3;

    logic [7:0]   sbox_t  [256];
    logic [7:0]   isbox_t [256];
    logic [127:0] exp_d [$];
    logic         exp_i [$];
    int unsigned  n_tests, n_fail, n_ret;

    sbox_array #(.LANES(4), .LAT(2), .INV_EN(1)) u_l4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(din[31:0]),
        .in_inv(dinv), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od0), .out_inv(oi[0]));
    sbox_array #(.LANES(1), .LAT(2), .INV_EN(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(din[7:0]),
        .in_inv(dinv), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od1), .out_inv(oi[1]));
    sbox_array #(.LANES(16), .LAT(1), .INV_EN(1)) u_l16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(din),
        .in_inv(dinv), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od2), .out_inv(oi[2]));
    sbox_array #(.LANES(1), .LAT(1), .INV_EN(0)) u_fwd (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .in_data(din[7:0]),
        .in_inv(dinv), .out_valid(ov[3]), .out_ready(ordy[3]), .out_data(od3), .out_inv(oi[3]));

    always #5 clk = ~clk;

    function automatic int unsigned lanes_of(input int unsigned k);
        case (k)
            0:       return 4;
            2:       return 16;
            default: return 1;
        endcase
    endfunction

    function automatic logic [127:0] od_of(input int unsigned k);
        case (k)
            0:       return {96'd0, od0};
            1:       return {120'd0, od1};
            2:       return od2;
            default: return {120'd0, od3};
        endcase
    endfunction

    // Reference: each lane indexes the FIPS-197 table; inverse only where supported.
    function automatic logic [127:0] model(input int unsigned k, input logic [127:0] d, input logic inv);
        logic [127:0] r;
        logic [7:0]   b;
        r = '0;
        for (int unsigned l = 0; l < lanes_of(k); l++) begin
            b = d[8*l +: 8];
            r[8*l +: 8] = (k != 3 && inv) ? isbox_t[b] : sbox_t[b];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive DUT k at the falling edge, then score what the rising edge will do.
    task automatic cycle(input int unsigned k, input logic v, input logic [127:0] d,
                         input logic inv, input logic rdy, output logic acc);
        logic [127:0] ed;
        logic         ei;
        @(negedge clk);
        iv      = '0;
        iv[k]   = v;
        din     = d;
        dinv    = inv;
        ordy    = '1;
        ordy[k] = rdy;
        #1;
        acc = v & ir[k];
        if (ov[k] && rdy) begin
            if (exp_d.size() == 0) begin
                check("unexpected_beat", 128'(ov[k]), 128'd0);
            end else begin
                ed = exp_d.pop_front();
                ei = exp_i.pop_front();
                check("out_data", od_of(k), ed);
                check("out_inv", 128'(oi[k]), 128'(ei));
                n_ret++;
            end
        end
        if (acc) begin
            exp_d.push_back(model(k, d, inv));
            exp_i.push_back(k != 3 ? inv : 1'b0);
        end
    endtask

    task automatic drain(input int unsigned k, input bit rnd);
        logic acc;
        for (int unsigned c = 0; c < 200 && exp_d.size() != 0; c++)
            cycle(k, 1'b0, '0, 1'b0, rnd ? ($urandom_range(0, 3) != 0) : 1'b1, acc);
        check("drain_empty", 128'(exp_d.size()), 128'd0);
    endtask

    // rt=1: even beats forward of x, odd beats inverse of S(x); x sweeps 0..255 in every lane.
    task automatic stream(input int unsigned k, input int unsigned n, input bit rt);
        logic [127:0] d;
        logic         inv;
        logic         acc;
        logic [7:0]   x;
        int unsigned  tries;
        for (int unsigned j = 0; j < n; j++) begin
            d   = '0;
            inv = rt ? j[0] : 1'($urandom_range(0, 1));
            for (int unsigned l = 0; l < lanes_of(k); l++) begin
                x = rt ? 8'(j / 2 + 37 * l) : 8'($urandom_range(0, 255));
                d[8*l +: 8] = (rt && inv) ? sbox_t[x] : x;
            end
            tries = 0;
            do begin
                cycle(k, $urandom_range(0, 7) != 0, d, inv, $urandom_range(0, 3) != 0, acc);
                tries++;
            end while (!acc && tries < 100);
            if (!acc) check("accept_timeout", 128'(acc), 128'd1);
        end
        drain(k, 1'b1);
    endtask

    logic        acc;
    int unsigned p, r0;
    logic [7:0]  bb;

    initial begin
        clk = 1'b0; rst_n = 1'b0; iv = '0; ordy = '1; din = '0; dinv = 1'b0;
        n_tests = 0; n_fail = 0; n_ret = 0;
        for (int unsigned i = 0; i < 256; i++) begin
            sbox_t[i] = SB[2047 - 8*i -: 8];
            isbox_t[sbox_t[i]] = 8'(i);
        end
        #12;
        check("rst_out_valid", 128'(ov), 128'd0);
        check("rst_in_ready", 128'(ir), 128'hf);
        check("rst_out_data", {od2[127:8], od0[31:8], od0[7:0] | od1 | od3}, 128'd0);
        check("rst_out_inv", 128'(oi), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        cycle(0, 1'b1, 128'h000153ff, 1'b0, 1'b1, acc);
        check("fwd_accept", 128'(acc), 128'd1);
        cycle(0, 1'b0, '0, 1'b0, 1'b1, acc);
        check("fwd_lat_early", 128'(ov[0]), 128'd0);
        cycle(0, 1'b0, '0, 1'b0, 1'b1, acc);
        check("fwd_lat_valid", 128'(ov[0]), 128'd1);
        check("fwd_data", 128'(od0), 128'h637ced16);
        check("fwd_inv", 128'(oi[0]), 128'd0);
        drain(0, 1'b0);

        cycle(0, 1'b1, 128'h637ced16, 1'b1, 1'b1, acc);
        check("inv_accept", 128'(acc), 128'd1);
        cycle(0, 1'b1, 128'h00000000, 1'b0, 1'b1, acc);
        check("b2b_accept", 128'(acc), 128'd1);
        cycle(0, 1'b0, '0, 1'b0, 1'b1, acc);
        check("inv_data", 128'(od0), 128'h000153ff);
        check("inv_inv", 128'(oi[0]), 128'd1);
        cycle(0, 1'b0, '0, 1'b0, 1'b1, acc);
        check("b2b_data", 128'(od0), 128'h63636363);
        check("b2b_inv", 128'(oi[0]), 128'd0);
        drain(0, 1'b0);

        p = 0;
        r0 = n_ret;
        for (int unsigned c = 0; c < 40 && (p < 6 || exp_d.size() != 0); c++) begin
            bb = 8'(p);
            cycle(0, p < 6, {96'd0, {4{bb}}}, 1'b0, c >= 4, acc);
            if (acc) p++;
            if (c == 2 || c == 3) begin
                check("bp_in_ready", 128'(ir[0]), 128'd0);
                check("bp_hold_valid", 128'(ov[0]), 128'd1);
                check("bp_hold_data", 128'(od0), 128'h63636363);
            end
            if (c == 3) check("bp_accepted", 128'(p), 128'd2);
            if (c >= 4 && c <= 9) check("bp_no_gap", 128'(ov[0]), 128'd1);
        end
        check("bp_retired", 128'(n_ret - r0), 128'd6);

        cycle(0, 1'b1, 128'h11111111, 1'b0, 1'b1, acc);
        cycle(0, 1'b1, 128'h22222222, 1'b0, 1'b1, acc);
        @(negedge clk);
        iv = '0;
        #1;
        check("mid_inflight", 128'(ov[0]), 128'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 128'(ov[0]), 128'd0);
        check("mid_rst_ready", 128'(ir[0]), 128'd1);
        check("mid_rst_data", 128'(od0), 128'd0);
        check("mid_rst_inv", 128'(oi[0]), 128'd0);
        exp_d.delete();
        exp_i.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int unsigned c = 0; c < 5; c++) begin
            cycle(0, 1'b0, '0, 1'b0, 1'b1, acc);
            check("no_stale", 128'(ov[0]), 128'd0);
        end
        cycle(0, 1'b1, 128'h53535353, 1'b0, 1'b1, acc);
        check("post_rst_accept", 128'(acc), 128'd1);
        drain(0, 1'b0);

        cycle(3, 1'b1, 128'h00, 1'b1, 1'b1, acc);
        check("fwdonly_accept", 128'(acc), 128'd1);
        cycle(3, 1'b0, '0, 1'b0, 1'b1, acc);
        check("fwdonly_valid", 128'(ov[3]), 128'd1);
        check("fwdonly_data", 128'(od3), 128'h63);
        check("fwdonly_inv", 128'(oi[3]), 128'd0);
        drain(3, 1'b0);
        stream(3, 200, 1'b0);

        stream(0, 200, 1'b0);
        stream(1, 512, 1'b1);
        stream(0, 512, 1'b1);
        stream(2, 512, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sbox_array.md
SBOX_ARRAY -- requirements
Module: sbox_array

Interface
REQ-001 The block SHALL have parameter LANES, default 4, giving the number of independent byte lanes (legal range 1..16).
REQ-002 The block SHALL have parameter LAT, default 2, giving the pipeline depth in cycles (legal values 1 or 2).
REQ-003 The block SHALL have parameter INV_EN, default 1; when it is 1 the inverse S-box is supported, and when it is 0 only the forward S-box is supported.
REQ-004 clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  is the reset; it SHALL be asynchronous and active-low.
REQ-006 in_valid  input  1  indicates that the upstream beat is present.
REQ-007 in_ready  output  1  indicates that the block accepts a beat this cycle.
REQ-008 in_data  input  8*LANES  carries the input bytes; lane i is bits [8i+7:8i].
REQ-009 in_inv  input  1  is the per-beat mode: 0 selects forward SubBytes, 1 selects InvSubBytes.
REQ-010 out_valid  output  1  indicates that the result beat is present.
REQ-011 out_ready  input  1  indicates that the downstream consumer accepts the beat.
REQ-012 out_data  output  8*LANES  carries the substituted bytes, using the same lane mapping as in_data.
REQ-013 out_inv  output  1  SHALL echo the in_inv value of the beat currently on out_data.

Function
REQ-014 The forward table SHALL be the FIPS-197 S-box (e.g. 00->63, 01->7C, 53->ED, FF->16).
REQ-015 The inverse table SHALL be the FIPS-197 inverse S-box (e.g. 63->00, 7C->01, ED->53, 16->FF).
REQ-016 Each lane SHALL be looked up independently; there SHALL be no cross-lane interaction.
REQ-017 With INV_EN=0:
  - in_inv SHALL be ignored and every lane SHALL use the forward table;
  - out_inv SHALL always be 0;
  - no inverse-table logic SHALL be generated.
REQ-018 A beat SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-019 A beat SHALL be retired on a rising edge where out_valid=1 and out_ready=1.
REQ-020 The pipeline SHALL consist of LAT register stages, each holding a valid bit, LANES data bytes and an inv bit.
REQ-021 Table lookup SHALL be combinational ahead of stage 1.
  - Stage 2 (LAT=2) SHALL be a pure register stage.
REQ-022 A stage SHALL load when it is empty or when its contents move onward in the same cycle (elastic pipeline, no bubbles).
REQ-023 in_ready SHALL equal (stage-1 empty) OR (stage 1 advances this cycle).
  - in_ready SHALL be combinational from out_ready and the stage valid bits only, never from in_valid.
REQ-024 Latency: an accepted beat with no backpressure SHALL appear on out_valid exactly LAT cycles after the accept edge.
REQ-025 Throughput SHALL be one beat per cycle while out_ready=1.
REQ-026 While out_valid=1 and out_ready=0:
  - out_data and out_inv SHALL hold stable;
  - beats in the stages SHALL hold;
  - no beat SHALL be dropped, duplicated or reordered.
REQ-027 With all LAT stages full and out_ready=0, in_ready SHALL be 0.
REQ-028 With all stages full and out_ready=1, the block SHALL retire one beat and accept one beat in the same cycle.
REQ-029 The mode SHALL be selectable per beat: consecutive beats alternating in_inv SHALL each use their own table with no pipeline flush.
REQ-030 Beats SHALL emerge strictly in acceptance order.
REQ-031 in_data SHALL be ignored whenever in_valid=0 or in_ready=0.

Reset
REQ-032 While rst_n=0:
  - all stage valid bits SHALL be 0;
  - out_valid SHALL be 0;
  - out_data SHALL be 0 and out_inv SHALL be 0;
  - in_ready SHALL be 1 (empty pipeline).
REQ-033 Assertion of rst_n SHALL take effect immediately without a clock edge and SHALL discard all beats in flight.
REQ-034 Release of rst_n SHALL be sampled synchronously.
  - The first beat SHALL be accepted on the first rising edge after release where in_valid=1.

Verification
REQ-035 The bench SHALL cover forward mode with LANES=4, LAT=2: in_data=32'h0001_53FF, in_inv=0, out_ready=1 -> out_data=32'h637C_ED16 with out_inv=0, exactly 2 cycles after accept.
REQ-036 The bench SHALL cover inverse mode: in_data=32'h637C_ED16, in_inv=1 -> out_data=32'h0001_53FF with out_inv=1.
  - It SHALL then send a back-to-back forward beat 32'h0000_0000 -> 32'h6363_6363 on the next cycle.
REQ-037 The bench SHALL cover backpressure: stream beats 32'h00..05 replicated per lane while holding out_ready=0 for 4 cycles.
  - in_ready SHALL go 0 after 2 beats are accepted.
  - out_data SHALL stay 63636363 while held.
  - After release all 6 results (63,7C,77,7B,F2,6B replicated) SHALL appear in order with no gaps or duplicates.
REQ-038 The bench SHALL cover reset mid-operation: with 2 beats in flight, drive rst_n=0 between edges.
  - out_valid SHALL go 0 immediately and in_ready SHALL be 1.
  - After release no stale beat SHALL emerge.
REQ-039 The bench SHALL cover INV_EN=0, LAT=1: in_data=8'h00 with in_inv=1 -> out_data=8'h63, out_inv=0, 1 cycle after accept.
REQ-040 The bench SHALL cover exhaustive round trip: for all 256 bytes in every lane, a forward beat followed by an inverse beat of the result SHALL return the original byte.
  - This SHALL be run for LANES=1, 4 and 16 with random out_ready toggling.
